// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared constants, types and the round-robin pick helper for the
// two-requester packet arbiter.
package mux2_rr_arbiter_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_GRANT = ST_GRANT
  } state_e;

  typedef struct packed {
    logic hit;
    logic idx;
  } arb_t;

  // A lone requester always wins; on a tie the priority pointer decides.
  function automatic arb_t rr_pick(input logic [1:0] req, input logic prio);
    arb_t r;
    r.hit = |req;
    case (req)
      2'b01:   r.idx = REQ0;
      2'b10:   r.idx = REQ1;
      2'b11:   r.idx = prio;
      default: r.idx = REQ0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_mux2_dw.sv
// DW-wide 2:1 data mux; sel=1 picks b.
module mux2_dw #(
  parameter int DW = 8
) (
  input  logic          sel,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter and packet sequencer for a shared 2:1 data mux.
// The grant is held from arbitration until the granted requester's last beat is accepted.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int DW        = 8,
  parameter int MAX_BEATS = 16,
  parameter int CW        = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    in_valid,
  input  logic [1:0]    in_last,
  input  logic [DW-1:0] in_data0,
  input  logic [DW-1:0] in_data1,
  output logic [1:0]    in_ready,
  output logic          out_valid,
  output logic          out_last,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          sel,
  output logic          busy,
  output logic [CW-1:0] beat_cnt,
  output logic          err_long
);

  localparam logic [CW:0] MAX_B = (CW+1)'(MAX_BEATS);

  state_e        state, state_nxt;
  logic          prio, prio_nxt;
  logic          sel_nxt, busy_nxt, err_nxt;
  logic [CW-1:0] cnt_nxt;
  logic [CW:0]   cnt_inc;
  logic          granted, accept;
  arb_t          arb;

  assign granted = (state == S_GRANT);
  assign accept  = granted & in_valid[sel] & out_ready;
  assign arb     = rr_pick(in_valid, prio);
  // One bit wider than the counter so the overlong test still fires once saturated.
  assign cnt_inc = {1'b0, beat_cnt} + 1'b1;

  always_comb begin
    out_valid = granted & in_valid[sel];
    out_last  = granted & in_last[sel];
    in_ready  = 2'b00;
    if (granted) in_ready[sel] = out_ready;
  end

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    sel_nxt   = sel;
    busy_nxt  = busy;
    err_nxt   = err_long;
    cnt_nxt   = beat_cnt;
    case (state)
      S_IDLE: begin
        if (arb.hit) begin
          state_nxt = S_GRANT;
          sel_nxt   = arb.idx;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
        end
      end
      S_GRANT: begin
        if (accept) begin
          cnt_nxt = (&beat_cnt) ? beat_cnt : cnt_inc[CW-1:0];
          if (cnt_inc > MAX_B) err_nxt = 1'b1;
          if (in_last[sel]) begin
            state_nxt = S_IDLE;
            prio_nxt  = ~sel;
            busy_nxt  = 1'b0;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      prio     <= REQ0;
      sel      <= REQ0;
      busy     <= 1'b0;
      beat_cnt <= '0;
      err_long <= 1'b0;
    end else begin
      state    <= state_nxt;
      prio     <= prio_nxt;
      sel      <= sel_nxt;
      busy     <= busy_nxt;
      beat_cnt <= cnt_nxt;
      err_long <= err_nxt;
    end
  end

  mux2_dw #(.DW(DW)) u_mux (
    .sel (sel),
    .a   (in_data0),
    .b   (in_data1),
    .y   (out_data)
  );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: stimulus pushes expected beats into a
// scoreboard queue; a negedge monitor pops and compares every accepted beat.
module tb_mux2_rr_arbiter;

  localparam int DW = 8;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    in_valid = '0;
  logic [1:0]    in_last  = '0;
  logic [DW-1:0] in_data0 = '0;
  logic [DW-1:0] in_data1 = '0;
  logic [1:0]    in_ready;
  logic          out_valid, out_last;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          sel, busy, err_long;
  logic [CW-1:0] beat_cnt;

  mux2_rr_arbiter #(.DW(DW), .MAX_BEATS(4), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
    .in_data0(in_data0), .in_data1(in_data1), .in_ready(in_ready),
    .out_valid(out_valid), .out_last(out_last), .out_data(out_data),
    .out_ready(out_ready), .sel(sel), .busy(busy), .beat_cnt(beat_cnt),
    .err_long(err_long)
  );

  always #5 clk = ~clk;

  typedef struct { logic s; logic [DW-1:0] d; logic l; } exp_t;
  exp_t sb_q[$];
  int   gap_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic push(input logic s, input logic [DW-1:0] d, input logic l);
    exp_t e;
    e.s = s; e.d = d; e.l = l;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one-hot ready every cycle, scoreboard compare on each handshake.
  int cyc = 0, last_cyc = 0;
  bit prev_last = 0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) prev_last = 0;
    else begin
      checks++;
      if (in_ready == 2'b11) begin
        errors++;
        $display("FAIL in_ready_onehot: got %b", in_ready);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: sel=%0d data=%0h last=%0d", sel, out_data, out_last);
        end else begin
          e = sb_q.pop_front();
          if (sel !== e.s || out_data !== e.d || out_last !== e.l) begin
            errors++;
            $display("FAIL sb_beat: got sel=%0d data=%0h last=%0d expected sel=%0d data=%0h last=%0d",
                     sel, out_data, out_last, e.s, e.d, e.l);
          end
        end
        if (prev_last) gap_q.push_back(cyc - last_cyc);
        prev_last = out_last;
        if (out_last) last_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_acc(input int r);
    int t = 0;
    forever begin
      @(negedge clk);
      if (in_ready[r] && in_valid[r]) break;
      if (++t > 200) begin
        errors++; checks++;
        $display("FAIL timeout_req%0d: no accept within 200 cycles", r);
        break;
      end
    end
    step();
  endtask

  task automatic drive(input int r, input int n, input logic [DW-1:0] base);
    for (int b = 0; b < n; b++) begin
      if (r == 0) in_data0 = base + DW'(b); else in_data1 = base + DW'(b);
      in_valid[r] = 1'b1;
      in_last[r]  = (b == n-1);
      wait_acc(r);
    end
    in_valid[r] = 1'b0;
    in_last[r]  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_cnt", 32'(beat_cnt), 0);
    chk("rst_err", 32'(err_long), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_oval", 32'(out_valid), 0);
    step();

    // single beat from requester 0, grant one cycle after valid
    out_ready = 1'b1;
    push(1'b0, 8'hA5, 1'b1);
    fork
      drive(0, 1, 8'hA5);
      begin
        @(negedge clk); chk("t1_idle_busy", 32'(busy), 0);
        @(negedge clk); chk("t1_grant_busy", 32'(busy), 1);
        chk("t1_grant_sel", 32'(sel), 0);
        chk("t1_grant_ready", 32'(in_ready), 32'b01);
      end
    join
    @(negedge clk);
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_cnt_after", 32'(beat_cnt), 1);
    step();

    // prio now points at requester 1: a tie goes to 1 first
    push(1'b1, 8'hC0, 1'b1);
    push(1'b0, 8'hB0, 1'b1);
    fork
      drive(0, 1, 8'hB0);
      drive(1, 1, 8'hC0);
    join
    chk("t1b_sb_empty", 32'(sb_q.size()), 0);

    // both requesters from reset, two 3-beat bursts each: order 0,1,0,1
    do_reset();
    out_ready = 1'b1;
    gap_q.delete();
    push(0, 8'h10, 0); push(0, 8'h11, 0); push(0, 8'h12, 1);
    push(1, 8'h20, 0); push(1, 8'h21, 0); push(1, 8'h22, 1);
    push(0, 8'h13, 0); push(0, 8'h14, 0); push(0, 8'h15, 1);
    push(1, 8'h23, 0); push(1, 8'h24, 0); push(1, 8'h25, 1);
    fork
      begin drive(0, 3, 8'h10); drive(0, 3, 8'h13); end
      begin drive(1, 3, 8'h20); drive(1, 3, 8'h23); end
    join
    chk("t2_sb_empty", 32'(sb_q.size()), 0);
    chk("t2_gap_count", 32'(gap_q.size()), 3);
    while (gap_q.size() > 0) chk("t2_bubble_gap", 32'(gap_q.pop_front()), 2);

    // requester 1, 4 beats, out_ready toggling 1,0,1,0...
    push(1, 8'h40, 0); push(1, 8'h41, 0); push(1, 8'h42, 0); push(1, 8'h43, 1);
    fork
      drive(1, 4, 8'h40);
      begin
        int exp_cnt = 0;
        int t = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (!busy && t < 20) begin @(negedge clk); t++; end
        for (int k = 0; k < 20 && exp_cnt < 4; k++) begin
          chk("t3_cnt_step", 32'(beat_cnt), 32'(exp_cnt));
          chk("t3_ready_mirror", 32'(in_ready), out_ready ? 32'b10 : 32'b00);
          if (out_ready) exp_cnt++;
          step();
          out_ready = ~out_ready;
          @(negedge clk);
        end
      end
    join
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_cnt_final", 32'(beat_cnt), 4);
    chk("t3_err", 32'(err_long), 0);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_sb_empty", 32'(sb_q.size()), 0);
    step();

    // 6-beat burst with MAX_BEATS=4: err_long set by the 5th acceptance
    for (int b = 0; b < 6; b++) push(0, 8'h80 + 8'(b), b == 5);
    push(1, 8'h90, 1);
    fork
      drive(0, 6, 8'h80);
      for (int k = 0; k < 6; k++) begin
        int t = 0;
        @(negedge clk);
        while (!(out_valid && out_ready) && t < 20) begin @(negedge clk); t++; end
        chk("t4_err_timing", 32'(err_long), 32'(k == 5));
      end
    join
    @(negedge clk);
    chk("t4_err_set", 32'(err_long), 1);
    chk("t4_cnt", 32'(beat_cnt), 6);
    step();
    drive(1, 1, 8'h90);
    @(negedge clk);
    chk("t4_err_sticky", 32'(err_long), 1);
    step();

    // reset on the 2nd beat of a 3-beat burst
    push(1, 8'h50, 0);
    in_data1 = 8'h50; in_last[1] = 1'b0; in_valid[1] = 1'b1;
    step();
    step();
    in_data1 = 8'h51; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = '0; in_last = '0;
    @(negedge clk);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_sel", 32'(sel), 0);
    chk("t5_cnt", 32'(beat_cnt), 0);
    chk("t5_err", 32'(err_long), 0);
    chk("t5_ready", 32'(in_ready), 0);
    step();
    push(1, 8'h58, 1);
    drive(1, 1, 8'h58);
    @(negedge clk);
    chk("t5_rearb_sel", 32'(sel), 1);
    chk("t5_sb_empty", 32'(sb_q.size()), 0);
    step();

    // granted requester 0 pauses 3 cycles while requester 1 waits
    push(0, 8'h60, 0); push(0, 8'h61, 1); push(1, 8'h70, 1);
    in_data0 = 8'h60; in_last[0] = 1'b0; in_valid[0] = 1'b1;
    wait_acc(0);
    in_valid[0] = 1'b0;
    in_data1 = 8'h70; in_last[1] = 1'b1; in_valid[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_oval", 32'(out_valid), 0);
      chk("t6_ready", 32'(in_ready), 32'b01);
      chk("t6_busy", 32'(busy), 1);
      chk("t6_sel", 32'(sel), 0);
      step();
    end
    fork
      drive(0, 1, 8'h61);
      begin wait_acc(1); in_valid[1] = 1'b0; in_last[1] = 1'b0; end
    join
    @(negedge clk);
    chk("t6_final_sel", 32'(sel), 1);
    chk("t6_sb_empty", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Round-robin arbiter and packet sequencer for a shared 2:1 data mux.
- Two requesters (0, 1) compete for one downstream valid/ready channel.
- The block grants one requester and holds the grant until that requester's last beat is accepted.
- It drives the mux select and gates the ready signals back to the requesters. It also counts beats per burst and flags overlong bursts.

Parameters:
- DW, 8, data width of each requester and of the output.
- MAX_BEATS, 16, burst beats allowed before `err_long` is set (>=1).
- CW, 5, beat counter width; must hold MAX_BEATS.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  2  per-requester beat valid; bit i = requester i.
- in_last  in  2  per-requester last-beat flag, qualified by in_valid.
- in_data0  in  DW  requester 0 data.
- in_data1  in  DW  requester 1 data.
- in_ready  out  2  per-requester ready; only the granted bit may be 1.
- out_valid  out  1  downstream valid.
- out_last  out  1  downstream last.
- out_data  out  DW  mux output; sel=1 selects in_data1, sel=0 selects in_data0.
- out_ready  in  1  downstream ready.
- sel  out  1  registered mux select (index of current/last grant).
- busy  out  1  1 while in GRANT state.
- beat_cnt  out  CW  beats accepted in current burst.
- err_long  out  1  sticky: a burst exceeded MAX_BEATS beats.

Behaviour:
- Reset (rst=1 at clk edge) forces:
  - state=IDLE, sel=0, busy=0, beat_cnt=0, err_long=0.
  - Priority pointer prio=0, so requester 0 wins a tie.
- Reset applied mid-burst abandons the burst immediately. No partial-burst recovery.
- States:
  - IDLE: in_ready=00, out_valid=0.
    - If no in_valid bit is set, stay in IDLE.
    - If exactly one bit is set, grant that requester.
    - If both are set, grant index prio.
    - On grant: sel<=granted index, busy<=1, beat_cnt<=0, next state GRANT.
    - Arbitration latency is one cycle: data can first pass in the cycle after in_valid rises.
  - GRANT, with g = sel:
    - out_valid = in_valid[g], out_last = in_last[g], out_data = mux(sel).
    - in_ready[g] = out_ready; other bit = 0.
    - These outputs are combinational from registered sel and the state.
    - Beat accepted when out_valid & out_ready:
      - beat_cnt <= beat_cnt+1, saturating at 2^CW-1.
      - If beat_cnt+1 > MAX_BEATS, err_long <= 1 (sticky until rst).
    - Accepted beat with out_last=1:
      - next state IDLE, prio <= ~g, busy <= 0.
      - beat_cnt holds its final value until the next grant.
- Exactly one bubble cycle (IDLE) occurs between bursts, even when the other requester is waiting. This is intentional, for a simple timing path.
- Fairness: after each completed burst the other requester has priority. A single requester re-granted alone is allowed.
- Requester i dropping in_valid mid-burst does not release the grant. Only an accepted last beat releases it.
- out_ready=0 stalls: no state change, beat_cnt held.
- The non-granted requester's in_valid and in_last are ignored entirely.
- sel changes only on the IDLE->GRANT transition, so the mux select is glitch-free within a burst.

Decomposition:
- Shared package:
  - State encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Requester index constants REQ0=1'b0, REQ1=1'b1.
- One natural sub-module: mux2_dw, a parameterised DW-wide 2:1 data mux driven by sel.
- FSM, priority pointer and counter stay in the top.

Test Plan:
- Reset, then in_valid=01 with in_last=1 on beat 1 and out_ready=1:
  - grant at cycle 1, sel=0, one beat passes, busy returns to 0.
  - afterwards beat_cnt=1 and prio=1.
- Both requesters assert from reset, each sending a 3-beat burst, out_ready=1:
  - grant order is 0,1,0,1.
  - one idle cycle between bursts.
  - in_ready is never 11.
- Requester 1 granted, out_ready toggles 1,0,1,0 for a 4-beat burst:
  - out_data tracks in_data1.
  - beat_cnt steps only on ready cycles, ends at 4.
  - in_ready[1] mirrors out_ready.
- MAX_BEATS=4, a 6-beat burst:
  - err_long rises in the same edge as the 5th beat acceptance and stays 1 through later bursts until rst.
- rst asserted on the 2nd beat of a 3-beat burst:
  - next cycle: busy=0, sel=0, beat_cnt=0, err_long=0, in_ready=00.
  - re-arbitration proceeds normally after reset.
- Granted requester drops in_valid for 3 cycles mid-burst while the other requests:
  - grant held, out_valid=0, other requester's in_ready stays 0 until the last beat completes.
